// File: rtl/ball_motion.sv
// Ball position/direction generator: advances the ball one STEP per resynchronized
// frame-clock rising edge, steered by keycode and bouncing off the screen edges.
module ball_motion #(
    parameter int unsigned X_CENTER = 320,
    parameter int unsigned Y_CENTER = 240,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SIZE     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       frame_tick,
    output logic [2:0] Dir
);

    localparam int unsigned PW = 10;
    localparam int unsigned AW = 11;

    localparam logic [AW-1:0] X_LO       = AW'(X_MIN + SIZE);
    localparam logic [AW-1:0] X_HI       = AW'(X_MAX - SIZE);
    localparam logic [AW-1:0] Y_LO       = AW'(Y_MIN + SIZE);
    localparam logic [AW-1:0] Y_HI       = AW'(Y_MAX - SIZE);
    localparam logic [AW-1:0] LO_BOUNCE_X = AW'(X_MIN + SIZE + STEP);
    localparam logic [AW-1:0] LO_BOUNCE_Y = AW'(Y_MIN + SIZE + STEP);
    localparam logic [AW-1:0] REACH      = AW'(SIZE + STEP);
    localparam logic [AW-1:0] X_LIMIT    = AW'(X_MAX);
    localparam logic [AW-1:0] Y_LIMIT    = AW'(Y_MAX);
    localparam logic [AW-1:0] STEP_W     = AW'(STEP);

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    dir_t          state;
    dir_t          state_nxt;
    dir_t          key_dir;
    logic          fc_s1;
    logic          fc_s2;
    logic          fc_s3;
    logic [AW-1:0] x_ext;
    logic [AW-1:0] y_ext;
    logic [PW-1:0] x_nxt;
    logic [PW-1:0] y_nxt;

    function automatic logic [PW-1:0] clamp(input logic [AW-1:0] v,
                                            input logic [AW-1:0] lo,
                                            input logic [AW-1:0] hi);
        logic [AW-1:0] r;
        r = v;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return PW'(r);
    endfunction

    // Subtract STEP without letting the 11-bit value wrap below zero
    function automatic logic [AW-1:0] sub_step(input logic [AW-1:0] v);
        return (v < STEP_W) ? '0 : v - STEP_W;
    endfunction

    assign x_ext     = {1'b0, BallX};
    assign y_ext     = {1'b0, BallY};
    assign Dir       = state;
    assign Ball_size = PW'(SIZE);

    // Frame clock resynchronizer and rising-edge pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_s1      <= 1'b0;
            fc_s2      <= 1'b0;
            fc_s3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            fc_s1      <= frame_clk;
            fc_s2      <= fc_s1;
            fc_s3      <= fc_s2;
            frame_tick <= fc_s2 & ~fc_s3;
        end
    end

    // Direction state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= DIR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Key decode then wall bounce; bounce wins over a key pushing into a wall
    always_comb begin
        key_dir   = state;
        state_nxt = state;
        case (keycode)
            KEY_UP:    key_dir = DIR_UP;
            KEY_DOWN:  key_dir = DIR_DOWN;
            KEY_LEFT:  key_dir = DIR_LEFT;
            KEY_RIGHT: key_dir = DIR_RIGHT;
            default:   key_dir = state;
        endcase
        if (frame_tick) begin
            state_nxt = key_dir;
            case (key_dir)
                DIR_DOWN:  if (y_ext + REACH > Y_LIMIT)  state_nxt = DIR_UP;
                DIR_UP:    if (y_ext < LO_BOUNCE_Y)      state_nxt = DIR_DOWN;
                DIR_RIGHT: if (x_ext + REACH > X_LIMIT)  state_nxt = DIR_LEFT;
                DIR_LEFT:  if (x_ext < LO_BOUNCE_X)      state_nxt = DIR_RIGHT;
                default:   state_nxt = key_dir;
            endcase
        end
    end

    // Next position along the post-bounce direction, clamped inside the legal window
    always_comb begin
        x_nxt = BallX;
        y_nxt = BallY;
        if (frame_tick) begin
            case (state_nxt)
                DIR_UP:    y_nxt = clamp(sub_step(y_ext), Y_LO, Y_HI);
                DIR_DOWN:  y_nxt = clamp(y_ext + STEP_W, Y_LO, Y_HI);
                DIR_LEFT:  x_nxt = clamp(sub_step(x_ext), X_LO, X_HI);
                DIR_RIGHT: x_nxt = clamp(x_ext + STEP_W, X_LO, X_HI);
                default: begin
                    x_nxt = BallX;
                    y_nxt = BallY;
                end
            endcase
        end
    end

    // Position registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BallX <= PW'(X_CENTER);
            BallY <= PW'(Y_CENTER);
        end else begin
            BallX <= x_nxt;
            BallY <= y_nxt;
        end
    end

endmodule
